// File: rtl/sprite_layer_compositor.sv
// rtl/sprite_layer_compositor.sv - N-layer priority pixel compositor with game-over flash FSM
module sprite_layer_compositor #(
  parameter int               N_LAYERS      = 12,
  parameter int               RGB_W         = 12,
  parameter bit               KEY_EN        = 1'b1,
  parameter logic [RGB_W-1:0] KEY_RGB       = 12'hF0F,
  parameter logic [RGB_W-1:0] OVER_RGB      = 12'h0F0,
  parameter int               FLASH_FRAMES  = 15,
  parameter int               FLASH_TOGGLES = 6
) (
  input  logic                      sys_clk,
  input  logic                      Reset,
  input  logic                      bright,
  input  logic                      vSync,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic                      game_over,
  output logic [RGB_W/3-1:0]        vgaR,
  output logic [RGB_W/3-1:0]        vgaG,
  output logic [RGB_W/3-1:0]        vgaB,
  output logic                      over_active
);

  localparam int         CW        = RGB_W / 3;
  localparam logic [7:0] FRAME_END = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] TOGGLE_N  = 8'(FLASH_TOGGLES);

  typedef enum logic [1:0] {RUN, FLASH_ON, FLASH_OFF, HOLD} state_t;

  logic [N_LAYERS-1:0]       en_q;
  logic [N_LAYERS*RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]          bg_q;
  logic                      bright_q;
  logic                      vs_d1, vs_d2;
  logic                      tick;
  state_t                    state;
  logic [7:0]                frame_cnt, toggle_cnt;
  logic [N_LAYERS-1:0]       vis;
  logic [RGB_W-1:0]          comp, pix;

  // Stage 1 plus the vSync synchroniser; sync regs reset high so release never fakes a falling edge.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      en_q     <= '0;
      rgb_q    <= '0;
      bg_q     <= '0;
      bright_q <= 1'b0;
      vs_d1    <= 1'b1;
      vs_d2    <= 1'b1;
    end else begin
      en_q     <= layer_en;
      rgb_q    <= layer_rgb;
      bg_q     <= bg_rgb;
      bright_q <= bright;
      vs_d1    <= vSync;
      vs_d2    <= vs_d1;
    end
  end

  assign tick = vs_d2 & ~vs_d1;

  // The FSM samples game_over alongside stage 1, so its state lines up with the stage-1 pixel.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state       <= RUN;
      frame_cnt   <= 8'd0;
      toggle_cnt  <= 8'd0;
      over_active <= 1'b0;
    end else if (!game_over) begin
      state       <= RUN;
      frame_cnt   <= 8'd0;
      toggle_cnt  <= 8'd0;
      over_active <= 1'b0;
    end else begin
      over_active <= 1'b1;
      case (state)
        RUN: begin
          state      <= FLASH_ON;
          frame_cnt  <= 8'd0;
          toggle_cnt <= 8'd0;
        end
        FLASH_ON, FLASH_OFF: begin
          if (tick) begin
            if (frame_cnt == FRAME_END) begin
              frame_cnt <= 8'd0;
              if (toggle_cnt == TOGGLE_N) begin
                state <= HOLD;
              end else begin
                state <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                if (toggle_cnt != 8'hFF) toggle_cnt <= toggle_cnt + 8'd1;
              end
            end else if (frame_cnt != 8'hFF) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        HOLD:    state <= HOLD;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    vis = '0;
    for (int i = 0; i < N_LAYERS; i++)
      vis[i] = en_q[i] && !(KEY_EN && (rgb_q[i*RGB_W +: RGB_W] == KEY_RGB));
  end

  // Scan from lowest priority upward so the lowest visible index is the last to assign.
  always_comb begin
    comp = bg_q;
    for (int i = N_LAYERS - 1; i >= 0; i--)
      if (vis[i]) comp = rgb_q[i*RGB_W +: RGB_W];
  end

  always_comb begin
    pix = comp;
    if (state == FLASH_ON || state == HOLD) pix = OVER_RGB;
    if (!bright_q) pix = '0;
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      vgaR <= '0;
      vgaG <= '0;
      vgaB <= '0;
    end else begin
      vgaR <= pix[3*CW-1 -: CW];
      vgaG <= pix[2*CW-1 -: CW];
      vgaB <= pix[CW-1:0];
    end
  end

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb/tb_sprite_layer_compositor.sv - directed bench for sprite_layer_compositor
module tb_sprite_layer_compositor;

  logic          sys_clk = 1'b0;
  logic          Reset;
  logic          bright;
  logic          vSync;
  logic [11:0]   layer_en;
  logic [143:0]  layer_rgb;
  logic [11:0]   bg_rgb;
  logic          game_over;
  logic [3:0]    vgaR, vgaG, vgaB, nk_R, nk_G, nk_B;
  logic          over_active, nk_over;
  logic [11:0]   out, nk_out;

  int passed = 0;
  int total  = 0;

  always #5 sys_clk = ~sys_clk;

  assign out    = {vgaR, vgaG, vgaB};
  assign nk_out = {nk_R, nk_G, nk_B};

  sprite_layer_compositor #(.FLASH_FRAMES(2), .FLASH_TOGGLES(3)) dut (
    .sys_clk(sys_clk), .Reset(Reset), .bright(bright), .vSync(vSync),
    .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .game_over(game_over), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .over_active(over_active)
  );

  sprite_layer_compositor #(.KEY_EN(1'b0)) dut_nokey (
    .sys_clk(sys_clk), .Reset(Reset), .bright(bright), .vSync(vSync),
    .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .game_over(game_over), .vgaR(nk_R), .vgaG(nk_G), .vgaB(nk_B),
    .over_active(nk_over)
  );

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge sys_clk);
  endtask

  task automatic set_layer(input int idx, input logic [11:0] c);
    layer_rgb[idx*12 +: 12] = c;
  endtask

  // One-cycle vSync low pulse, then enough idle cycles for the tick to reach the output.
  task automatic frame_pulse();
    vSync = 1'b0;
    cycles(1);
    vSync = 1'b1;
    cycles(4);
  endtask

  task automatic test_reset();
    Reset = 1'b1; bright = 1'b1; vSync = 1'b1; game_over = 1'b0;
    layer_en = 12'hFFF; layer_rgb = '1; bg_rgb = 12'hABC;
    cycles(3);
    total++;
    if (out !== 12'h000) $display("FAIL reset_out: got %h expected 000", out); else passed++;
    total++;
    if (over_active !== 1'b0) $display("FAIL reset_over: got %b expected 0", over_active); else passed++;
    Reset = 1'b0;
  endtask

  task automatic test_priority();
    layer_rgb = '0; bg_rgb = 12'h000; bright = 1'b1;
    layer_en = 12'b0000_0010_0100;
    set_layer(2, 12'h123); set_layer(5, 12'h456);
    cycles(2);
    total++;
    if (out !== 12'h123) $display("FAIL prio_2_over_5: got %h expected 123", out); else passed++;
    for (int i = 0; i < 12; i++) set_layer(i, 12'(12'h100 + i));
    layer_en = 12'hFFF;
    cycles(2);
    total++;
    if (out !== 12'h100) $display("FAIL prio_all_on: got %h expected 100", out); else passed++;
    layer_en = 12'b1000_0000_0000;
    cycles(2);
    total++;
    if (out !== 12'h10B) $display("FAIL prio_layer11: got %h expected 10b", out); else passed++;
    layer_en = 12'h000; bg_rgb = 12'h5A5;
    cycles(2);
    total++;
    if (out !== 12'h5A5) $display("FAIL prio_none_bg: got %h expected 5a5", out); else passed++;
  endtask

  task automatic test_color_key();
    layer_rgb = '0; bg_rgb = 12'h69C; layer_en = 12'b0000_0000_1000;
    set_layer(3, 12'hF0F);
    cycles(2);
    total++;
    if (out !== 12'h69C) $display("FAIL key_bg: got %h expected 69c", out); else passed++;
    total++;
    if (nk_out !== 12'hF0F) $display("FAIL nokey_f0f: got %h expected f0f", nk_out); else passed++;
    layer_en = 12'b0000_0001_0010;
    set_layer(1, 12'hF0F); set_layer(4, 12'hABC);
    cycles(2);
    total++;
    if (out !== 12'hABC) $display("FAIL key_fallthrough: got %h expected abc", out); else passed++;
    total++;
    if (nk_out !== 12'hF0F) $display("FAIL nokey_layer1: got %h expected f0f", nk_out); else passed++;
  endtask

  task automatic test_blanking();
    layer_rgb = '0; bg_rgb = 12'h777; layer_en = 12'b0000_0000_0100;
    set_layer(2, 12'h123);
    bright = 1'b0;
    cycles(2);
    total++;
    if (out !== 12'h000) $display("FAIL blank_out: got %h expected 000", out); else passed++;
    bright = 1'b1;
    cycles(3);
    bright = 1'b0;
    cycles(1);
    total++;
    if (out !== 12'h123) $display("FAIL blank_pre: got %h expected 123", out); else passed++;
    bright = 1'b1;
    cycles(1);
    total++;
    if (out !== 12'h000) $display("FAIL blank_pulse: got %h expected 000", out); else passed++;
    cycles(1);
    total++;
    if (out !== 12'h123) $display("FAIL blank_post: got %h expected 123", out); else passed++;
  endtask

  task automatic test_flash();
    logic [11:0] exp_seq [12];
    exp_seq = '{12'h0F0, 12'h123, 12'h123, 12'h0F0, 12'h0F0, 12'h123,
                12'h123, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
    game_over = 1'b1;
    cycles(1);
    total++;
    if (out !== 12'h123) $display("FAIL flash_latency1: got %h expected 123", out); else passed++;
    total++;
    if (over_active !== 1'b1) $display("FAIL flash_over_on: got %b expected 1", over_active); else passed++;
    cycles(1);
    total++;
    if (out !== 12'h0F0) $display("FAIL flash_latency2: got %h expected 0f0", out); else passed++;
    for (int p = 0; p < 12; p++) begin
      frame_pulse();
      total++;
      if (out !== exp_seq[p] || over_active !== 1'b1)
        $display("FAIL flash_frame%0d: got %h/%b expected %h/1", p + 1, out, over_active, exp_seq[p]);
      else passed++;
    end
  endtask

  task automatic test_abort();
    game_over = 1'b0;
    cycles(3);
    game_over = 1'b1;
    cycles(3);
    for (int p = 0; p < 3; p++) frame_pulse();
    total++;
    if (out !== 12'h123) $display("FAIL abort_in_off: got %h expected 123", out); else passed++;
    game_over = 1'b0;
    cycles(1);
    total++;
    if (over_active !== 1'b0) $display("FAIL abort_over: got %b expected 0", over_active); else passed++;
    cycles(1);
    total++;
    if (out !== 12'h123) $display("FAIL abort_out: got %h expected 123", out); else passed++;
    game_over = 1'b1;
    cycles(3);
    frame_pulse();
    total++;
    if (out !== 12'h0F0) $display("FAIL abort_cnt_clear: got %h expected 0f0", out); else passed++;
    game_over = 1'b0;
    cycles(1);
    total++;
    if (out !== 12'h0F0) $display("FAIL abort_on_hold1: got %h expected 0f0", out); else passed++;
    cycles(1);
    total++;
    if (out !== 12'h123) $display("FAIL abort_on_run: got %h expected 123", out); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    game_over = 1'b1;
    cycles(3);
    for (int p = 0; p < 8; p++) frame_pulse();
    total++;
    if (out !== 12'h0F0) $display("FAIL hold_reached: got %h expected 0f0", out); else passed++;
    #3 Reset = 1'b1;
    #1;
    total++;
    if (out !== 12'h000 || over_active !== 1'b0)
      $display("FAIL async_reset: got %h/%b expected 000/0", out, over_active);
    else passed++;
    cycles(2);
    Reset = 1'b0;
    cycles(2);
    total++;
    if (out !== 12'h0F0 || over_active !== 1'b1)
      $display("FAIL post_reset_reflash: got %h/%b expected 0f0/1", out, over_active);
    else passed++;
    frame_pulse();
    total++;
    if (out !== 12'h0F0) $display("FAIL no_spurious_tick: got %h expected 0f0", out); else passed++;
    frame_pulse();
    total++;
    if (out !== 12'h123) $display("FAIL post_reset_toggle: got %h expected 123", out); else passed++;
    game_over = 1'b0;
    cycles(2);
    total++;
    if (out !== 12'h123 || over_active !== 1'b0)
      $display("FAIL post_reset_run: got %h/%b expected 123/0", out, over_active);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_color_key();
    test_blanking();
    test_flash();
    test_abort();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
